// File: rtl/and_or_pkg.sv
// Shared definitions for the AND/OR selector self-test driver: mode
// encodings, sequencer states, LFSR feedback taps and helper functions.
package and_or_pkg;

    typedef enum logic [1:0] {
        MODE_OR   = 2'b00,
        MODE_AND  = 2'b01,
        MODE_ALT  = 2'b10,
        MODE_RAND = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRIVE  = 2'b01,
        ST_SAMPLE = 2'b10,
        ST_FINISH = 2'b11
    } state_t;

    // Feedback taps for x^7+x^6+1: the new bit is cur[6]^cur[5]
    localparam logic [6:0] LFSR_TAPS = 7'h60;

    localparam logic [9:0] FIRST_FAIL_NONE = 10'h3FF;

    // One Fibonacci step: shift left, feed the tap parity into bit 0
    function automatic logic [6:0] lfsr7Next(input logic [6:0] cur);
        return {cur[5:0], ^(cur & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    function automatic logic [6:0] lfsr7Seed(input logic [6:0] seed);
        return (seed == 7'h00) ? 7'h01 : seed;
    endfunction

endpackage

// File: rtl/and_or_lfsr7.sv
// 7-bit maximal-length Fibonacci LFSR that produces the operand sequence.
module and_or_lfsr7
    import and_or_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_seed,
    input  logic       i_load,
    input  logic       i_step,
    output logic [6:0] o_value
);

    logic [6:0] r_value;

    // Reload the (zero-safe) seed on reset or load, otherwise advance on step
    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_value <= lfsr7Seed(i_seed);
        end else if (i_step) begin
            r_value <= lfsr7Next(r_value);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/and_or_selector_driver.sv
// Self-test sequencer for the AND/OR selector: drives LFSR operand pairs
// and a select bit, checks the returned {sel, data} against a golden
// model and reports pass, mismatch count and first failing vector.
module and_or_selector_driver
    import and_or_pkg::*;
#(
    parameter int unsigned NUM_VECS = 16,
    parameter int unsigned SETTLE   = 1,
    parameter logic [6:0]  SEED_A   = 7'h5A,
    parameter logic [6:0]  SEED_B   = 7'h23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    output logic [6:0] a_out,
    output logic [6:0] b_out,
    output logic       sel_out,
    input  logic [7:0] res_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [9:0] first_fail
);

    localparam logic [9:0] LAST_INDEX  = 10'(NUM_VECS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [6:0] SEED_A_FIX  = lfsr7Seed(SEED_A);
    localparam logic [6:0] SEED_B_FIX  = lfsr7Seed(SEED_B);

    state_t     r_state;
    state_t     w_nextState;
    mode_t      r_mode;
    logic [3:0] r_settle;
    logic [9:0] r_index;
    logic [6:0] r_aOut;
    logic [6:0] r_bOut;
    logic       r_sel;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_errCnt;
    logic [9:0] r_firstFail;

    logic [6:0] w_lfsrA;
    logic [6:0] w_lfsrB;
    logic [6:0] w_nextA;
    logic [6:0] w_nextB;
    logic       w_startRun;
    logic       w_settleDone;
    logic       w_lastVec;
    logic       w_stepLfsr;
    logic [7:0] w_expected;
    logic       w_mismatch;
    logic       w_initSel;
    logic       w_nextSel;

    assign w_startRun   = (r_state == ST_IDLE) && start;
    assign w_settleDone = (r_settle == SETTLE_LAST);
    assign w_lastVec    = (r_index == LAST_INDEX);
    assign w_stepLfsr   = (r_state == ST_SAMPLE) && !w_lastVec;
    assign w_nextA      = lfsr7Next(w_lfsrA);
    assign w_nextB      = lfsr7Next(w_lfsrB);
    assign w_expected   = {r_sel, r_sel ? (r_aOut & r_bOut) : (r_aOut | r_bOut)};
    assign w_mismatch   = (r_state == ST_SAMPLE) && (res_in != w_expected);

    and_or_lfsr7 u_lfsrA (
        .clk     (clk),
        .rst     (rst),
        .i_seed  (SEED_A),
        .i_load  (w_startRun),
        .i_step  (w_stepLfsr),
        .o_value (w_lfsrA)
    );

    and_or_lfsr7 u_lfsrB (
        .clk     (clk),
        .rst     (rst),
        .i_seed  (SEED_B),
        .i_load  (w_startRun),
        .i_step  (w_stepLfsr),
        .o_value (w_lfsrB)
    );

    // Select bit for the first vector, chosen from the requested mode
    always_comb begin
        w_initSel = 1'b0;
        case (mode_t'(mode))
            MODE_AND:  w_initSel = 1'b1;
            MODE_RAND: w_initSel = SEED_A_FIX[0];
            default:   w_initSel = 1'b0;
        endcase
    end

    // Select bit for the following vector, from the mode latched at start
    always_comb begin
        w_nextSel = r_sel;
        case (r_mode)
            MODE_ALT:  w_nextSel = ~r_sel;
            MODE_RAND: w_nextSel = w_nextA[0];
            default:   w_nextSel = r_sel;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Sequencer next-state: settle, sample once, repeat until the last vector
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_nextState = ST_DRIVE;
            ST_DRIVE:  if (w_settleDone) w_nextState = ST_SAMPLE;
            ST_SAMPLE: w_nextState = w_lastVec ? ST_FINISH : ST_DRIVE;
            ST_FINISH: w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // Operand, counter and result registers updated per sequencer state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= MODE_OR;
            r_settle    <= 4'd0;
            r_index     <= 10'd0;
            r_aOut      <= 7'h00;
            r_bOut      <= 7'h00;
            r_sel       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_errCnt    <= 8'd0;
            r_firstFail <= FIRST_FAIL_NONE;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode      <= mode_t'(mode);
                        r_settle    <= 4'd0;
                        r_index     <= 10'd0;
                        r_aOut      <= SEED_A_FIX;
                        r_bOut      <= SEED_B_FIX;
                        r_sel       <= w_initSel;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_errCnt    <= 8'd0;
                        r_firstFail <= FIRST_FAIL_NONE;
                    end
                end
                ST_DRIVE: begin
                    r_settle <= w_settleDone ? 4'd0 : r_settle + 4'd1;
                end
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_errCnt != 8'hFF) begin
                            r_errCnt <= r_errCnt + 8'd1;
                        end
                        if (r_firstFail == FIRST_FAIL_NONE) begin
                            r_firstFail <= r_index;
                        end
                    end
                    if (w_lastVec) begin
                        r_done <= 1'b1;
                        r_pass <= (r_errCnt == 8'd0) && !w_mismatch;
                    end else begin
                        r_aOut  <= w_nextA;
                        r_bOut  <= w_nextB;
                        r_sel   <= w_nextSel;
                        r_index <= r_index + 10'd1;
                    end
                end
                ST_FINISH: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign a_out      = r_aOut;
    assign b_out      = r_bOut;
    assign sel_out    = r_sel;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_errCnt;
    assign first_fail = r_firstFail;

endmodule

// File: doc/and_or_selector_driver.md
Name: and_or_selector_driver

Overview:
- Initiator/checker for the AND/OR selector datapath.
- Generates pseudo-random 7-bit operand pairs plus a mode-select bit and drives them toward the selector.
- Samples the returned 8-bit result, compares it against an internal golden model, and reports a pass/fail summary.
- Sits on the requesting side of the selector interface and serves as the built-in self-test sequencer.

Parameters:
NUM_VECS, 16, vectors per run (1..1023)
SETTLE, 1, cycles operands are held before the result is sampled (1..15)
SEED_A, 7'h5A, LFSR seed for operand A; zero is replaced by 7'h01
SEED_B, 7'h23, LFSR seed for operand B; zero is replaced by 7'h01

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle run request, sampled in IDLE only
mode  in  2  00 OR-only, 01 AND-only, 10 alternate (first vector OR), 11 sel = LFSR_A bit 0
a_out  out  7  operand A to selector
b_out  out  7  operand B to selector
sel_out  out  1  1=AND, 0=OR
res_in  in  8  selector result {sel, data[6:0]}
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  1 if last run had zero mismatches; held until next start
err_cnt  out  8  mismatch count, saturates at 255
first_fail  out  10  index of first mismatching vector; 10'h3FF if none

Behaviour:
- Reset, synchronous active-high, takes priority over everything: state=IDLE; a_out=b_out=0; sel_out=0; busy=0; done=0; pass=0; err_cnt=0; first_fail=3FF; LFSRs reloaded with their seeds. Reset mid-run aborts the run without asserting done.
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE -> DRIVE on start=1:
  - latch mode;
  - clear err_cnt and pass; set first_fail=3FF; vector index=0;
  - load a_out/b_out from the seeds and set sel_out per mode;
  - busy=1 from the next cycle.
- DRIVE: hold outputs for SETTLE cycles (settle counter), then go to SAMPLE.
- SAMPLE, one cycle:
  - expected = {sel_out, sel_out ? a_out&b_out : a_out|b_out};
  - if res_in != expected: err_cnt increments, saturating at 255; first_fail is captured only if it is still 3FF.
  - If index == NUM_VECS-1, go to FINISH. Otherwise step both LFSRs, update sel_out, index+1, go to DRIVE.
- FINISH, one cycle: done=1; pass=(err_cnt==0); busy=0 on the following cycle; return to IDLE. a_out/b_out/sel_out keep their last values.
- LFSRs: 7-bit Fibonacci, polynomial x^7+x^6+1, period 127. Each step is next = {cur[5:0], cur[6]^cur[5]}. They step only at SAMPLE->DRIVE.
- sel update:
  - mode 10 toggles sel each vector;
  - mode 11 uses bit 0 of the new LFSR_A value;
  - modes 00/01 hold sel constant.
- start while busy is ignored. A mode change mid-run is ignored.
- Timing: start sampled at cycle 0 gives busy at cycles 1..N*(SETTLE+1)+1, with done at cycle N*(SETTLE+1)+1.
- The comparison includes bit 7, so a selector that drops or inverts the select echo is flagged.

Decomposition:
- Package and_or_pkg holds:
  - mode encodings MODE_OR/MODE_AND/MODE_ALT/MODE_RAND;
  - the FSM state enum;
  - the LFSR tap constant;
  - FIRST_FAIL_NONE=10'h3FF.
- One sub-module, and_or_lfsr7 (seed, load, step, value), instantiated twice.
- The golden compare stays inline.

Test Plan:
- Loopback to a correct selector model, mode=10, defaults, start at cycle 0 -> done at cycle 33; pass=1; err_cnt=0; first_fail=3FF; vector 0 drives a=5A, b=23, sel=0, with res_in=7B expected.
- Loopback with res_in[7] inverted, mode=01 -> all 16 vectors fail; err_cnt=16; first_fail=0; pass=0.
- NUM_VECS=300, res_in tied to 0, mode=00 -> err_cnt saturates at 255; no wrap to 0.
- Assert rst at the 5th SAMPLE -> next cycle busy=0, done never pulses, outputs zeroed; a fresh start reruns from SEED_A/SEED_B.
- Pulse start at cycle 10 of a running job -> ignored; done timing unchanged; exactly one done pulse.
- SEED_A=0 -> first a_out=01; the LFSR never locks up over 127 steps.
